// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// div_pkg
// Shared types and constants for the DIV/IDIV sequencing logic.
// Revision: 1.0
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } div_seq_state_t;

    localparam logic [7:0] DIV_FAULT_VECTOR = 8'h00;

    function automatic logic [31:0] form_dividend(
        input logic        is_8_bit,
        input logic [15:0] dx,
        input logic [15:0] ax
    );
        return is_8_bit ? {16'h0000, ax} : {dx, ax};
    endfunction

    function automatic logic [15:0] form_divisor(
        input logic        is_8_bit,
        input logic [15:0] src
    );
        return is_8_bit ? {8'h00, src[7:0]} : src;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// div_sequencer
// Drives one DIV/IDIV through the shared divider and packs AX/DX write-backs.
// Revision: 1.0
// ============================================================================
module div_sequencer
    import div_pkg::*;
#(
    parameter int WATCHDOG_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue,
    input  logic        flush,
    input  logic        is_8_bit,
    input  logic        is_signed,
    input  logic [15:0] ax_in,
    input  logic [15:0] dx_in,
    input  logic [15:0] src_in,
    output logic        div_start,
    output logic        div_is_8_bit,
    output logic        div_is_signed,
    output logic [31:0] div_dividend,
    output logic [15:0] div_divisor,
    input  logic        div_busy,
    input  logic        div_complete,
    input  logic        div_error,
    input  logic [15:0] div_quotient,
    input  logic [15:0] div_remainder,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic        timeout,
    output logic        wr_ax_en,
    output logic        wr_dx_en,
    output logic [15:0] ax_out,
    output logic [15:0] dx_out
);

    localparam int               CNT_W    = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WATCHDOG_CYCLES - 1);

    div_seq_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_8_bit_q, op_8_bit_d;
    logic             op_signed_q, op_signed_d;
    logic [15:0]      ax_q, ax_d;
    logic [15:0]      dx_q, dx_d;
    logic [15:0]      src_q, src_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic             timeout_q, timeout_d;
    logic             wr_ax_en_q, wr_ax_en_d;
    logic             wr_dx_en_q, wr_dx_en_d;
    logic [15:0]      ax_out_q, ax_out_d;
    logic [15:0]      dx_out_q, dx_out_d;
    logic [15:0]      res_ax;
    logic [15:0]      res_dx;

    // Byte divide returns AH=remainder, AL=quotient; DX is left untouched.
    always_comb begin
        res_ax = div_quotient;
        res_dx = div_remainder;
        if (op_8_bit_q) begin
            res_ax = {div_remainder[7:0], div_quotient[7:0]};
            res_dx = dx_out_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_8_bit_d  = op_8_bit_q;
        op_signed_d = op_signed_q;
        ax_d        = ax_q;
        dx_d        = dx_q;
        src_d       = src_q;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        timeout_d   = 1'b0;
        wr_ax_en_d  = 1'b0;
        wr_dx_en_d  = 1'b0;
        ax_out_d    = ax_out_q;
        dx_out_d    = dx_out_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (issue) begin
                    op_8_bit_d  = is_8_bit;
                    op_signed_d = is_signed;
                    ax_d        = ax_in;
                    dx_d        = dx_in;
                    src_d       = src_in;
                    state_d     = START;
                end
            end
            START: begin
                cnt_d = '0;
                if (flush) begin
                    state_d = IDLE;
                end else if (!div_busy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A flushed result is never reported, even if it lands this cycle.
                if (flush) begin
                    state_d = DRAIN;
                end else if (div_complete) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (div_error) begin
                        fault_d = 1'b1;
                    end else begin
                        wr_ax_en_d = 1'b1;
                        wr_dx_en_d = !op_8_bit_q;
                        ax_out_d   = res_ax;
                        dx_out_d   = res_dx;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    done_d    = 1'b1;
                    fault_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (div_complete || !div_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_8_bit_q  <= 1'b0;
            op_signed_q <= 1'b0;
            ax_q        <= '0;
            dx_q        <= '0;
            src_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            timeout_q   <= 1'b0;
            wr_ax_en_q  <= 1'b0;
            wr_dx_en_q  <= 1'b0;
            ax_out_q    <= '0;
            dx_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_8_bit_q  <= op_8_bit_d;
            op_signed_q <= op_signed_d;
            ax_q        <= ax_d;
            dx_q        <= dx_d;
            src_q       <= src_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            timeout_q   <= timeout_d;
            wr_ax_en_q  <= wr_ax_en_d;
            wr_dx_en_q  <= wr_dx_en_d;
            ax_out_q    <= ax_out_d;
            dx_out_q    <= dx_out_d;
        end
    end

    // Start must land in the cycle after issue, so it is decoded from state.
    assign div_start     = (state_q == START) && !div_busy && !flush;
    assign div_is_8_bit  = op_8_bit_q;
    assign div_is_signed = op_signed_q;
    assign div_dividend  = form_dividend(op_8_bit_q, dx_q, ax_q);
    assign div_divisor   = form_divisor(op_8_bit_q, src_q);

    assign busy     = busy_q;
    assign done     = done_q;
    assign fault    = fault_q;
    assign timeout  = timeout_q;
    assign wr_ax_en = wr_ax_en_q;
    assign wr_dx_en = wr_dx_en_q;
    assign ax_out   = ax_out_q;
    assign dx_out   = dx_out_q;

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_div_sequencer
// Randomised and directed scoreboard bench with a behavioural divider stub.
// Revision: 1.0
// ============================================================================
module tb_div_sequencer;

    localparam int WD = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue = 1'b0, flush = 1'b0, is_8_bit = 1'b0, is_signed = 1'b0;
    logic [15:0] ax_in = '0, dx_in = '0, src_in = '0;
    logic        div_start, div_is_8_bit, div_is_signed;
    logic [31:0] div_dividend;
    logic [15:0] div_divisor;
    logic        div_busy, div_complete, div_error;
    logic [15:0] div_quotient, div_remainder;
    logic        busy, done, fault, timeout, wr_ax_en, wr_dx_en;
    logic [15:0] ax_out, dx_out;

    div_sequencer #(.WATCHDOG_CYCLES(WD)) dut (
        .clk(clk), .reset(reset), .issue(issue), .flush(flush),
        .is_8_bit(is_8_bit), .is_signed(is_signed),
        .ax_in(ax_in), .dx_in(dx_in), .src_in(src_in),
        .div_start(div_start), .div_is_8_bit(div_is_8_bit), .div_is_signed(div_is_signed),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_busy(div_busy), .div_complete(div_complete), .div_error(div_error),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .busy(busy), .done(done), .fault(fault), .timeout(timeout),
        .wr_ax_en(wr_ax_en), .wr_dx_en(wr_dx_en), .ax_out(ax_out), .dx_out(dx_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // x86 DIV/IDIV semantics in plain integer arithmetic.
    function automatic void model_op(input logic [15:0] a, input logic [15:0] d, input logic [15:0] s,
                                     input logic b8, input logic sg,
                                     output logic err, output logic [15:0] q, output logic [15:0] r);
        longint n, dv, qq, rr, lo, hi;
        if (b8) begin
            n  = sg ? longint'($signed(a)) : longint'(a);
            dv = sg ? longint'($signed(s[7:0])) : longint'(s[7:0]);
            lo = sg ? -128 : 0;
            hi = sg ? 127 : 255;
        end else begin
            n  = sg ? longint'($signed({d, a})) : longint'({d, a});
            dv = sg ? longint'($signed(s)) : longint'(s);
            lo = sg ? -32768 : 0;
            hi = sg ? 32767 : 65535;
        end
        err = 1'b0;
        q   = '0;
        r   = '0;
        if (dv == 0) begin
            err = 1'b1;
        end else begin
            qq = n / dv;
            rr = n % dv;
            if (qq < lo || qq > hi) err = 1'b1;
            else begin
                q = 16'(qq);
                r = 16'(rr);
            end
        end
    endfunction

    function automatic logic [32:0] stub_calc(input logic [31:0] dvd, input logic [15:0] dvs,
                                              input logic b8, input logic sg);
        logic e;
        logic [15:0] q, r;
        model_op(dvd[15:0], dvd[31:16], dvs, b8, sg, e, q, r);
        return {e, q, r};
    endfunction

    // ---------------- divider stub ----------------
    logic        stub_hang = 1'b0, stub_drop = 1'b0, stub_force_busy = 1'b0;
    int          stub_lat_next = 0;
    int          rnd_lat = 1;
    logic        s_busy, s_complete, s_error;
    logic [15:0] s_q, s_r;
    int          s_cnt;
    logic [32:0] calc_now;

    assign calc_now      = stub_calc(div_dividend, div_divisor, div_is_8_bit, div_is_signed);
    assign div_busy      = s_busy | stub_force_busy;
    assign div_complete  = s_complete;
    assign div_error     = s_error;
    assign div_quotient  = s_q;
    assign div_remainder = s_r;

    initial begin
        forever begin
            @(negedge clk);
            rnd_lat = (stub_lat_next != 0) ? stub_lat_next : int'($urandom_range(1, 6));
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            s_busy <= 1'b0; s_complete <= 1'b0; s_error <= 1'b0;
            s_q <= '0; s_r <= '0; s_cnt <= 0;
        end else if (s_busy) begin
            if (s_complete) begin
                s_busy <= 1'b0; s_complete <= 1'b0; s_error <= 1'b0;
            end else if (stub_drop) begin
                s_busy <= 1'b0;
            end else if (!stub_hang) begin
                if (s_cnt == 1) s_complete <= 1'b1;
                s_cnt <= s_cnt - 1;
            end
        end else if (div_start) begin
            s_busy     <= 1'b1;
            s_error    <= calc_now[32];
            s_q        <= calc_now[31:16];
            s_r        <= calc_now[15:0];
            s_cnt      <= calc_now[32] ? 0 : rnd_lat - 1;
            s_complete <= !stub_hang && (calc_now[32] || rnd_lat == 1);
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        fault, timeout, wr_ax, wr_dx, busy;
        logic [15:0] ax, dx;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    logic [15:0] m_ax = '0, m_dx = '0;
    logic [31:0] exp_dvd = '0;
    logic [15:0] exp_dvs = '0;
    logic        exp_b8 = 1'b0, exp_sg = 1'b0;
    int          last_cmpl = -10;

    task automatic push_expect(input logic [15:0] a, input logic [15:0] d, input logic [15:0] s,
                               input logic b8, input logic sg, input int at_cyc);
        exp_t e;
        logic err;
        logic [15:0] q, r;
        model_op(a, d, s, b8, sg, err, q, r);
        e.fault = err; e.timeout = 1'b0; e.busy = 1'b0;
        e.wr_ax = !err; e.wr_dx = !err && !b8;
        e.cyc   = err ? at_cyc : -1;
        if (!err) begin
            if (b8) m_ax = {r[7:0], q[7:0]};
            else begin m_ax = q; m_dx = r; end
        end
        e.ax = m_ax; e.dx = m_dx;
        sb_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (div_complete) last_cmpl = cyc;
                if (div_start) begin
                    chk("start_while_busy", div_busy, 0);
                    chk("div_dividend", div_dividend, exp_dvd);
                    chk("div_divisor", div_divisor, exp_dvs);
                    chk("div_mode", {div_is_8_bit, div_is_signed}, {exp_b8, exp_sg});
                end
                if (done) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_done", done, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("fault", fault, e.fault);
                        chk("timeout", timeout, e.timeout);
                        chk("wr_ax_en", wr_ax_en, e.wr_ax);
                        chk("wr_dx_en", wr_dx_en, e.wr_dx);
                        chk("ax_out", ax_out, e.ax);
                        chk("dx_out", dx_out, e.dx);
                        chk("busy_at_done", busy, e.busy);
                        if (e.cyc >= 0) chk("done_cycle", cyc, e.cyc);
                        else            chk("done_latency", cyc, last_cmpl + 1);
                    end
                end else if (fault || timeout || wr_ax_en || wr_dx_en) begin
                    chk("stray_pulse", {fault, timeout, wr_ax_en, wr_dx_en}, 0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_issue(input logic [15:0] a, input logic [15:0] d, input logic [15:0] s,
                            input logic b8, input logic sg, input bit push, input bit dup);
        ax_in = a; dx_in = d; src_in = s; is_8_bit = b8; is_signed = sg; issue = 1'b1;
        exp_dvd = b8 ? {16'h0000, a} : {d, a};
        exp_dvs = b8 ? {8'h00, s[7:0]} : s;
        exp_b8 = b8; exp_sg = sg;
        if (push) push_expect(a, d, s, b8, sg, cyc + 3);
        @(posedge clk); #1;
        if (dup) begin
            ax_in = ~a; src_in = s ^ 16'h5a5a; is_8_bit = !b8;
            @(posedge clk); #1;
        end
        issue = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while ((sb_q.size() != 0 || busy) && n < maxc) begin
            @(posedge clk); #1; n++;
        end
        if (n >= maxc) chk("wait_done_expired", n, 0);
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((busy || div_busy) && n < maxc) begin
            @(posedge clk); #1; n++;
        end
        if (n >= maxc) chk("wait_idle_expired", n, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {busy, done, fault, timeout, wr_ax_en, wr_dx_en,
                            div_start, div_is_8_bit, div_is_signed}, 0);
        chk({tag, "_wb"}, {ax_out, dx_out}, 0);
        chk({tag, "_dividend"}, div_dividend, 0);
        chk({tag, "_divisor"}, div_divisor, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got still running expected finished");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int tcyc;
        exp_t te;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed operations with known answers.
        do_issue(16'h0064, 16'h0000, 16'h0007, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_done(40);
        chk("tp_u8_ax", ax_out, 16'h020E);

        do_issue(16'hFF9C, 16'hFFFF, 16'h0007, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_done(40);
        chk("tp_s16_ax", ax_out, 16'hFFF2);
        chk("tp_s16_dx", dx_out, 16'hFFFE);

        wait_idle(20);
        do_issue(16'h1234, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_done(40);
        wait_idle(20);
        do_issue(16'h0100, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_done(40);
        chk("tp_err_keep", {ax_out, dx_out}, {16'hFFF2, 16'hFFFE});

        // Flush while waiting: the result must never be reported.
        wait_idle(20);
        stub_lat_next = 10;
        do_issue(16'h4000, 16'h0000, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!div_start && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) chk("flush_start_seen", n, 0);
        repeat (2) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_drain_busy", busy, 1);
        wait_idle(40);
        stub_lat_next = 0;

        // Flush while held in START, then reissue with the divider still busy.
        stub_force_busy = 1'b1;
        do_issue(16'h0050, 16'h0000, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            chk("held_start", {busy, div_start}, 2'b10);
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_start_idle", busy, 0);
        do_issue(16'h03E8, 16'h0000, 16'h0019, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) begin
            chk("start_waits_busy", div_start, 0);
            @(posedge clk); #1;
        end
        stub_force_busy = 1'b0;
        wait_done(40);
        chk("reissue_ax", ax_out, 16'h0028);
        chk("reissue_dx", dx_out, 16'h0000);

        // Randomised operations, some with ignored issue pulses while busy.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a, d, s;
            logic b8, sg;
            bit dup;
            a   = 16'($urandom);
            s   = 16'($urandom);
            d   = 16'($urandom);
            b8  = 1'($urandom_range(0, 1));
            sg  = 1'($urandom_range(0, 1));
            dup = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) s = 16'h0000;
            if (b8 && !sg) a[15:8] = 8'($urandom_range(0, (s[7:0] == 0) ? 0 : int'(s[7:0]) - 1));
            else if (b8) a[15:8] = {8{a[7]}};
            else if (sg && $urandom_range(0, 3) != 0) d = {16{a[15]}};
            else if (!sg && $urandom_range(0, 3) != 0) d = 16'($urandom_range(0, (s == 0) ? 0 : int'(s) - 1));
            wait_idle(50);
            do_issue(a, d, s, b8, sg, 1'b1, dup);
            wait_done(60);
        end

        // Divider that never completes: watchdog fault, then drain.
        wait_idle(50);
        stub_hang = 1'b1;
        tcyc = cyc;
        do_issue(16'h0010, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        te.fault = 1'b1; te.timeout = 1'b1; te.wr_ax = 1'b0; te.wr_dx = 1'b0; te.busy = 1'b1;
        te.ax = m_ax; te.dx = m_dx; te.cyc = tcyc + 2 + WD;
        sb_q.push_back(te);
        n = 0;
        while (sb_q.size() != 0 && n < 60) begin @(posedge clk); #1; n++; end
        if (n >= 60) chk("timeout_expired", n, 0);
        repeat (3) begin
            chk("drain_busy", busy, 1);
            @(posedge clk); #1;
        end
        stub_drop = 1'b1;
        @(posedge clk); #1;
        stub_drop = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("drain_exit", busy, 0);
        stub_hang = 1'b0;

        // Reset in the middle of WAIT.
        wait_idle(20);
        stub_lat_next = 20;
        do_issue(16'h0200, 16'h0000, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        m_ax = '0;
        m_dx = '0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        stub_lat_next = 0;
        @(posedge clk); #1;

        do_issue(16'h0064, 16'h0000, 16'h0007, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_done(40);
        chk("post_reset_ax", ax_out, 16'h020E);
        chk("post_reset_dx", dx_out, 16'h0000);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
